// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and data-memory wait/timeout.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       waddr_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_op_MEM,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             EN_PC,
    output logic             EN_IF_ID,
    output logic             EN_ID_EX,
    output logic             EN_EX_MEM,
    output logic             EN_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_ERR
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_stall;
    logic            load_use;
    logic            branch_rule;

    assign mem_stall = dmem_op_MEM & ~dmem_ack & (state != S_ERR);
    assign load_use  = MemRead_EX & (waddr_EX != 5'd0) &
                       ((use_rs1_ID & (rs1_ID == waddr_EX)) |
                        (use_rs2_ID & (rs2_ID == waddr_EX)));
    assign dmem_req  = rst & dmem_op_MEM & (state != S_ERR);

    // Zero-latency controls, resolved strictly by priority: error > mem stall > branch > load-use.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        EN_PC       = 1'b0;
        EN_IF_ID    = 1'b0;
        EN_ID_EX    = 1'b0;
        EN_EX_MEM   = 1'b0;
        EN_MEM_WB   = 1'b0;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        branch_rule = 1'b0;
        if (!rst || state == S_ERR || mem_stall) begin
            // frozen: all enables stay low
        end else if (branch_taken_EX) begin
            {EN_PC, EN_IF_ID, EN_ID_EX, EN_EX_MEM, EN_MEM_WB} = 5'b11111;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            branch_rule = 1'b1;
        end else if (load_use) begin
            {EN_ID_EX, EN_EX_MEM, EN_MEM_WB} = 3'b111;
            flush_ID_EX = 1'b1;
        end else begin
            {EN_PC, EN_IF_ID, EN_ID_EX, EN_EX_MEM, EN_MEM_WB} = 5'b11111;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_stall) begin
                        state    <= S_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                        state   <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!EN_PC && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (branch_rule && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
